// File: rtl/hb_chain_pkg.sv
// rtl/hb_chain_pkg.sv - shared types and helpers for the halfband chain controller
package hb_chain_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLUSH  = 2'd1,
      SETTLE = 2'd2,
      RUN    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      DECIM1 = 2'd0,
      DECIM2 = 2'd1,
      DECIM4 = 2'd2
   } rate_t;

   // Rate codes 2 and 3 both mean decimate-by-4; fold 3 onto 2.
   function automatic rate_t norm_rate(input logic [1:0] r);
      return r[1] ? DECIM4 : rate_t'(r);
   endfunction

   // {hb1_bypass, hb2_bypass}: hb1 runs for decim 2 and 4, hb2 only for decim 4.
   function automatic logic [1:0] bypass_map(input rate_t r);
      return {(r == DECIM1), (r != DECIM4)};
   endfunction

endpackage

// File: rtl/hb_chain_if.sv
// rtl/hb_chain_if.sv - sample/strobe bus between the chain controller and its environment
interface hb_chain_if #(
   parameter int WIDTH = 18
);
   logic             stb_in;
   logic [WIDTH-1:0] data_in;
   logic             hb1_stb_in;
   logic [WIDTH-1:0] hb1_data_in;
   logic             chain_stb;
   logic [WIDTH-1:0] chain_data;
   logic             stb_out;
   logic [WIDTH-1:0] data_out;

   // Environment side: sources input samples and the hb2 output, sinks the forwarded streams.
   modport master (
      output stb_in, data_in, chain_stb, chain_data,
      input  hb1_stb_in, hb1_data_in, stb_out, data_out
   );

   // Controller side.
   modport slave (
      input  stb_in, data_in, chain_stb, chain_data,
      output hb1_stb_in, hb1_data_in, stb_out, data_out
   );
endinterface

// File: rtl/hb_chain_overrun.sv
// rtl/hb_chain_overrun.sv - input strobe rate policing; built only with HB_CHAIN_OVERRUN_CHECK_EN
`ifdef HB_CHAIN_OVERRUN_CHECK_EN
module hb_chain_overrun (
   input  logic clk,
   input  logic rst,
   input  logic i_window,
   input  logic i_check,
   input  logic i_stb,
   input  logic i_clr,
   output logic o_accept,
   output logic o_overrun
);
   logic r_prev_accept;
   logic r_overrun;
   logic w_drop;

   // A strobe directly behind an accepted one is too fast for a decimating chain.
   assign w_drop    = i_window & i_check & i_stb & r_prev_accept;
   assign o_accept  = i_window & i_stb & ~w_drop;
   assign o_overrun = r_overrun;

   // Track the previous accept; sticky flag where a new violation beats a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_accept <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_prev_accept <= o_accept;
         if (w_drop)
            r_overrun <= 1'b1;
         else if (i_clr)
            r_overrun <= 1'b0;
      end
   end
endmodule
`endif

// File: rtl/hb_chain_ctrl.sv
// rtl/hb_chain_ctrl.sv - halfband chain sequencer; HB_CHAIN_OVERRUN_CHECK_EN enables overrun policing
module hb_chain_ctrl
   import hb_chain_pkg::*;
#(
   parameter int WIDTH          = 18,
   parameter int FLUSH_CYCLES   = 16,
   parameter int SETTLE_OUTPUTS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [1:0] rate,
   input  logic       clr_overrun,
   output logic       hb1_rst,
   output logic       hb2_rst,
   output logic       hb1_bypass,
   output logic       hb2_bypass,
   output logic       active,
   output logic       overrun,
   hb_chain_if.slave  bus
);
   localparam int FW = $clog2(FLUSH_CYCLES) + 1;
   localparam int SW = $clog2(SETTLE_OUTPUTS) + 1;
   localparam logic [FW-1:0] FLUSH_LAST  = FW'(FLUSH_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_OUTPUTS > 0) ? SETTLE_OUTPUTS - 1 : 0);
   localparam bit NO_SETTLE = (SETTLE_OUTPUTS == 0);

   state_t           r_state, w_next;
   rate_t            r_rate_q, w_rate_norm;
   logic [FW-1:0]    r_flush_cnt;
   logic [SW-1:0]    r_settle_cnt;
   logic             w_load_rate;
   logic             w_window;
   logic             w_accept;
   logic             r_hb1_stb;
   logic [WIDTH-1:0] r_hb1_data;
   logic             r_stb_out;
   logic [WIDTH-1:0] r_data_out;

   assign w_rate_norm = norm_rate(rate);
   assign w_window    = (r_state == SETTLE) || (r_state == RUN);

   // Next state; run=0 wins everywhere, a rate change from SETTLE/RUN re-flushes.
   always_comb begin
      w_next      = r_state;
      w_load_rate = 1'b0;
      if (!run) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               w_next      = FLUSH;
               w_load_rate = 1'b1;
            end
            FLUSH: begin
               if (r_flush_cnt == FLUSH_LAST)
                  w_next = (NO_SETTLE || r_rate_q == DECIM1) ? RUN : SETTLE;
            end
            SETTLE: begin
               if (w_rate_norm != r_rate_q) begin
                  w_next      = FLUSH;
                  w_load_rate = 1'b1;
               end else if (bus.chain_stb && r_settle_cnt == SETTLE_LAST) begin
                  w_next = RUN;
               end
            end
            RUN: begin
               if (w_rate_norm != r_rate_q) begin
                  w_next      = FLUSH;
                  w_load_rate = 1'b1;
               end
            end
            default: w_next = IDLE;
         endcase
      end
   end

   // State, latched rate and the flush/settle counters (restart from zero on every entry).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_rate_q     <= DECIM1;
         r_flush_cnt  <= '0;
         r_settle_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_load_rate)
            r_rate_q <= w_rate_norm;
         if (r_state == FLUSH && w_next == FLUSH)
            r_flush_cnt <= r_flush_cnt + 1'b1;
         else
            r_flush_cnt <= '0;
         if (r_state == SETTLE && w_next == SETTLE) begin
            if (bus.chain_stb)
               r_settle_cnt <= r_settle_cnt + 1'b1;
         end else begin
            r_settle_cnt <= '0;
         end
      end
   end

`ifdef HB_CHAIN_OVERRUN_CHECK_EN
   hb_chain_overrun u_overrun (
      .clk       (clk),
      .rst       (rst),
      .i_window  (w_window),
      .i_check   (r_rate_q != DECIM1),
      .i_stb     (bus.stb_in),
      .i_clr     (clr_overrun),
      .o_accept  (w_accept),
      .o_overrun (overrun)
   );
`else
   logic w_unused_clr;
   assign w_unused_clr = clr_overrun;
   assign w_accept     = w_window & bus.stb_in;
   assign overrun      = 1'b0;
`endif

   // Registered input and output forwarding; data holds when no strobe passes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hb1_stb  <= 1'b0;
         r_hb1_data <= '0;
         r_stb_out  <= 1'b0;
         r_data_out <= '0;
      end else begin
         r_hb1_stb <= w_accept;
         if (w_accept)
            r_hb1_data <= bus.data_in;
         r_stb_out <= (r_state == RUN) && bus.chain_stb;
         if (r_state == RUN && bus.chain_stb)
            r_data_out <= bus.chain_data;
      end
   end

   assign hb1_rst                  = (r_state == IDLE) || (r_state == FLUSH);
   assign hb2_rst                  = hb1_rst;
   assign {hb1_bypass, hb2_bypass} = bypass_map(r_rate_q);
   assign active                   = (r_state == RUN);
   assign bus.hb1_stb_in           = r_hb1_stb;
   assign bus.hb1_data_in          = r_hb1_data;
   assign bus.stb_out              = r_stb_out;
   assign bus.data_out             = r_data_out;

endmodule

// File: tb/tb_hb_chain_ctrl.sv
// tb/tb_hb_chain_ctrl.sv - self-checking bench for hb_chain_ctrl
module tb_hb_chain_ctrl;
`ifdef HB_CHAIN_OVERRUN_CHECK_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif
   localparam logic [17:0] M5 = 18'h3FFFB;

   logic       clk = 1'b0;
   logic       rst, run, clr_overrun;
   logic [1:0] rate;
   logic       hb1_rst, hb2_rst, hb1_bypass, hb2_bypass, active, overrun;
   int         n_checks = 0;
   int         n_errors = 0;

   hb_chain_if #(.WIDTH(18)) bus ();

   hb_chain_ctrl #(.WIDTH(18), .FLUSH_CYCLES(16), .SETTLE_OUTPUTS(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .rate        (rate),
      .clr_overrun (clr_overrun),
      .hb1_rst     (hb1_rst),
      .hb2_rst     (hb2_rst),
      .hb1_bypass  (hb1_bypass),
      .hb2_bypass  (hb2_bypass),
      .active      (active),
      .overrun     (overrun),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          reps;
      logic        run;
      logic [1:0]  rate;
      logic        stb;
      logic [17:0] data;
      logic        cstb;
      logic [17:0] cdata;
      logic        clr;
      logic        e_rst;
      logic        e_byp1;
      logic        e_byp2;
      logic        e_hstb;
      logic [17:0] e_hdata;
      logic        e_sout;
      logic [17:0] e_dout;
      logic        e_act;
      logic        e_ovr;
   } vec_t;

   vec_t vecs[9];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic stb, input logic [17:0] d, input logic cstb,
                         input logic [17:0] cd, input logic clr);
      bus.stb_in     = stb;
      bus.data_in    = d;
      bus.chain_stb  = cstb;
      bus.chain_data = cd;
      clr_overrun    = clr;
   endtask

   initial begin
      rst = 1'b1; run = 1'b1; rate = 2'd2;
      set_in(1'b1, 18'd55, 1'b1, 18'd66, 1'b1);

      // Reset values (reset dominates run and strobes).
      for (int k = 0; k < 5; k++) cyc();
      chk("rst.hb1_rst", hb1_rst, 1);
      chk("rst.hb2_rst", hb2_rst, 1);
      chk("rst.hb1_bypass", hb1_bypass, 1);
      chk("rst.hb2_bypass", hb2_bypass, 1);
      chk("rst.stb_out", bus.stb_out, 0);
      chk("rst.data_out", bus.data_out, 0);
      chk("rst.hb1_stb_in", bus.hb1_stb_in, 0);
      chk("rst.hb1_data_in", bus.hb1_data_in, 0);
      chk("rst.active", active, 0);
      chk("rst.overrun", overrun, 0);

      // Decim-1 table: settle skipped, forwarding and run-drop forwarding.
      //            reps run rate stb data cstb cdata clr | rst b1 b2 hstb hdata sout dout act ovr
      vecs[0] = '{1,  1'b0, 2'd3, 1'b0, 18'd0, 1'b0, 18'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 18'd0, 1'b0, 18'd0,  1'b0, 1'b0};
      vecs[1] = '{16, 1'b1, 2'd0, 1'b0, 18'd0, 1'b0, 18'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 18'd0, 1'b0, 18'd0,  1'b0, 1'b0};
      vecs[2] = '{1,  1'b1, 2'd0, 1'b0, 18'd0, 1'b0, 18'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 18'd0, 1'b0, 18'd0,  1'b1, 1'b0};
      vecs[3] = '{1,  1'b1, 2'd0, 1'b1, M5,    1'b0, 18'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, M5,    1'b0, 18'd0,  1'b1, 1'b0};
      vecs[4] = '{1,  1'b1, 2'd0, 1'b0, 18'd0, 1'b1, M5,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, M5,    1'b1, M5,     1'b1, 1'b0};
      vecs[5] = '{1,  1'b1, 2'd0, 1'b1, 18'd7, 1'b1, 18'd3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 18'd7, 1'b1, 18'd3,  1'b1, 1'b0};
      vecs[6] = '{1,  1'b1, 2'd0, 1'b1, 18'd9, 1'b0, 18'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 18'd9, 1'b0, 18'd3,  1'b1, 1'b0};
      vecs[7] = '{1,  1'b0, 2'd0, 1'b0, 18'd0, 1'b1, 18'd11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 18'd9, 1'b1, 18'd11, 1'b0, 1'b0};
      vecs[8] = '{2,  1'b0, 2'd0, 1'b0, 18'd0, 1'b0, 18'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 18'd9, 1'b0, 18'd11, 1'b0, 1'b0};

      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            run = vecs[i].run; rate = vecs[i].rate;
            set_in(vecs[i].stb, vecs[i].data, vecs[i].cstb, vecs[i].cdata, vecs[i].clr);
            cyc();
            chk($sformatf("v%0d.hb1_rst", i), hb1_rst, vecs[i].e_rst);
            chk($sformatf("v%0d.hb2_rst", i), hb2_rst, vecs[i].e_rst);
            chk($sformatf("v%0d.hb1_bypass", i), hb1_bypass, vecs[i].e_byp1);
            chk($sformatf("v%0d.hb2_bypass", i), hb2_bypass, vecs[i].e_byp2);
            chk($sformatf("v%0d.hb1_stb_in", i), bus.hb1_stb_in, vecs[i].e_hstb);
            chk($sformatf("v%0d.hb1_data_in", i), bus.hb1_data_in, vecs[i].e_hdata);
            chk($sformatf("v%0d.stb_out", i), bus.stb_out, vecs[i].e_sout);
            chk($sformatf("v%0d.data_out", i), bus.data_out, vecs[i].e_dout);
            chk($sformatf("v%0d.active", i), active, vecs[i].e_act);
            chk($sformatf("v%0d.overrun", i), overrun, vecs[i].e_ovr);
         end
      end

      // Decim-2 start-up: 16-cycle flush, 8 suppressed outputs, then RUN.
      set_in(1'b0, 18'd0, 1'b0, 18'd0, 1'b0);
      rate = 2'd1; run = 1'b1;
      for (int k = 0; k < 16; k++) begin
         cyc();
         chk("t2.flush_rst", hb1_rst, 1);
         chk("t2.flush_active", active, 0);
      end
      cyc();
      chk("t2.hb1_rst_low", hb1_rst, 0);
      chk("t2.hb2_rst_low", hb2_rst, 0);
      chk("t2.hb1_bypass", hb1_bypass, 0);
      chk("t2.hb2_bypass", hb2_bypass, 1);
      chk("t2.settle_active", active, 0);
      for (int k = 0; k < 16; k++) begin
         set_in((k % 2) == 0, 18'd1000, (k % 2) == 0, 18'(k), 1'b0);
         cyc();
         chk("t2.hb1_stb_in", bus.hb1_stb_in, ((k % 2) == 0) ? 1 : 0);
         chk("t2.hb1_data_in", bus.hb1_data_in, 1000);
         chk("t2.suppressed", bus.stb_out, 0);
         chk("t2.active", active, (k >= 14) ? 1 : 0);
      end
      set_in(1'b0, 18'd0, 1'b1, 18'd123, 1'b0);
      cyc();
      chk("t2.first_out_stb", bus.stb_out, 1);
      chk("t2.first_out_data", bus.data_out, 123);
      set_in(1'b0, 18'd0, 1'b0, 18'd0, 1'b0);
      cyc();
      chk("t2.out_stb_low", bus.stb_out, 0);
      chk("t2.data_hold", bus.data_out, 123);
      chk("t2.no_overrun", overrun, 0);

      // Overrun: back-to-back strobes, clear racing a violation, clear alone.
      set_in(1'b1, 18'd100, 1'b0, 18'd0, 1'b0);
      cyc();
      chk("t4.c0_hstb", bus.hb1_stb_in, 1);
      chk("t4.c0_hdata", bus.hb1_data_in, 100);
      chk("t4.c0_ovr", overrun, 0);
      set_in(1'b1, 18'd200, 1'b0, 18'd0, 1'b0);
      cyc();
      chk("t4.c1_hstb", bus.hb1_stb_in, OVR_EN ? 0 : 1);
      chk("t4.c1_hdata", bus.hb1_data_in, OVR_EN ? 100 : 200);
      chk("t4.c1_ovr", overrun, OVR_EN ? 1 : 0);
      set_in(1'b1, 18'd300, 1'b0, 18'd0, 1'b0);
      cyc();
      chk("t4.c2_hstb", bus.hb1_stb_in, 1);
      chk("t4.c2_hdata", bus.hb1_data_in, 300);
      chk("t4.c2_ovr", overrun, OVR_EN ? 1 : 0);
      set_in(1'b1, 18'd400, 1'b0, 18'd0, 1'b1);
      cyc();
      chk("t4.c3_hstb", bus.hb1_stb_in, OVR_EN ? 0 : 1);
      chk("t4.c3_ovr_set_wins", overrun, OVR_EN ? 1 : 0);
      set_in(1'b0, 18'd0, 1'b0, 18'd0, 1'b1);
      cyc();
      chk("t4.c4_ovr_cleared", overrun, 0);
      set_in(1'b0, 18'd0, 1'b0, 18'd0, 1'b0);
      cyc();
      chk("t4.c5_ovr", overrun, 0);

      // Rate change mid-run: 1 -> 2, re-flush and re-settle; 3 afterwards is the same rate.
      rate = 2'd2;
      cyc();
      chk("t5.active_drop", active, 0);
      chk("t5.rst_assert", hb1_rst, 1);
      for (int k = 1; k < 16; k++) begin
         cyc();
         chk("t5.flush_rst", hb2_rst, 1);
      end
      cyc();
      chk("t5.rst_low", hb1_rst, 0);
      chk("t5.hb1_bypass", hb1_bypass, 0);
      chk("t5.hb2_bypass", hb2_bypass, 0);
      chk("t5.settle_active", active, 0);
      for (int k = 0; k < 8; k++) begin
         set_in(1'b0, 18'd0, 1'b1, 18'd9, 1'b0);
         cyc();
         chk("t5.suppressed", bus.stb_out, 0);
         chk("t5.active", active, (k == 7) ? 1 : 0);
      end
      rate = 2'd3;
      set_in(1'b0, 18'd0, 1'b1, 18'd77, 1'b0);
      cyc();
      chk("t5.rate3_active", active, 1);
      chk("t5.rate3_stb_out", bus.stb_out, 1);
      chk("t5.rate3_data_out", bus.data_out, 77);

      // Run drop mid-SETTLE, then a full fresh flush and settle.
      set_in(1'b0, 18'd0, 1'b0, 18'd0, 1'b0);
      run = 1'b0;
      cyc();
      chk("t6.idle_rst", hb1_rst, 1);
      chk("t6.idle_active", active, 0);
      chk("t6.rate_q_kept", hb2_bypass, 0);
      run = 1'b1; rate = 2'd2;
      for (int k = 0; k < 17; k++) cyc();
      chk("t6.settle1_rst", hb1_rst, 0);
      for (int k = 0; k < 3; k++) begin
         set_in(1'b0, 18'd0, 1'b1, 18'd5, 1'b0);
         cyc();
         chk("t6.pre_drop_sup", bus.stb_out, 0);
         chk("t6.pre_drop_active", active, 0);
      end
      set_in(1'b0, 18'd0, 1'b0, 18'd0, 1'b0);
      run = 1'b0;
      cyc();
      chk("t6.drop_rst", hb1_rst, 1);
      chk("t6.drop_active", active, 0);
      run = 1'b1;
      for (int k = 0; k < 16; k++) begin
         cyc();
         chk("t6.reflush_rst", hb1_rst, 1);
      end
      cyc();
      chk("t6.resettle_rst", hb1_rst, 0);
      chk("t6.resettle_active", active, 0);
      for (int k = 0; k < 8; k++) begin
         set_in(1'b0, 18'd0, 1'b1, 18'd6, 1'b0);
         cyc();
         chk("t6.fresh_settle_active", active, (k == 7) ? 1 : 0);
      end

      // Reset mid-operation returns everything to reset values.
      set_in(1'b0, 18'd0, 1'b0, 18'd0, 1'b0);
      rst = 1'b1;
      cyc();
      chk("t7.hb1_rst", hb1_rst, 1);
      chk("t7.hb1_bypass", hb1_bypass, 1);
      chk("t7.hb2_bypass", hb2_bypass, 1);
      chk("t7.active", active, 0);
      chk("t7.hb1_data_in", bus.hb1_data_in, 0);
      chk("t7.data_out", bus.data_out, 0);
      chk("t7.overrun", overrun, 0);
      rst = 1'b0;
      cyc();
      chk("t7.restart_flush", hb1_rst, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
